fcc_label_scan_ctrl: RTL and testbench

First-pass connected-component labelling sequencer for the FCC point grid memory (ROWS x COLS cells, one label plus one is_ground flag per cell, 1-cycle registered read, synchronous write). On start it raster-scans the grid, reads each cell's ground flag and its left and up neighbour labels, then writes back a provisional cluster label. It reports label equivalences for a downstream union/merge stage, and signals completion to the top-level clustering FSM.

---
 rtl/fcc_label_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fcc_label_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcc_label_scan_ctrl.sv
// First-pass connected-component labelling sequencer for the FCC point grid.
// Raster-scans the grid one cell every five cycles, derives a provisional
// label from the cell's ground flag and its left/up neighbours, writes it
// back and reports label equivalences for a downstream merge stage.
module fcc_label_scan_ctrl #(
    parameter int ROWS    = 30,
    parameter int COLS    = 30,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 5,
    parameter int LABEL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_we,
    output logic [ROW_W-1:0]   mem_wr_row,
    output logic [COL_W-1:0]   mem_wr_col,
    output logic [LABEL_W-1:0] mem_wr_label,
    output logic               mem_wr_is_ground,
    output logic [ROW_W-1:0]   mem_rd_row,
    output logic [COL_W-1:0]   mem_rd_col,
    input  logic [LABEL_W-1:0] mem_rd_label,
    input  logic               mem_rd_is_ground,
    output logic               eq_valid,
    output logic [LABEL_W-1:0] eq_a,
    output logic [LABEL_W-1:0] eq_b,
    output logic [LABEL_W-1:0] label_count,
    output logic               overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_RC, S_RL, S_RU, S_WU, S_WR, S_DONE
    } state_t;

    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(COLS - 1);
    localparam logic [LABEL_W-1:0] LBL_MAX  = '1;
    localparam logic [LABEL_W-1:0] LBL_ONE  = LABEL_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic [LABEL_W-1:0]   r_next_label;
    logic [LABEL_W-1:0]   r_label_count;
    logic                 r_overflow;
    logic                 r_cur_ground;
    logic [LABEL_W-1:0]   r_left_lbl;
    logic [LABEL_W-1:0]   r_up_lbl;

    logic                 w_last_col;
    logic                 w_last_cell;
    logic                 w_need_new;
    logic                 w_eq;
    logic [LABEL_W-1:0]   w_min;
    logic [LABEL_W-1:0]   w_max;
    logic [LABEL_W-1:0]   w_wr_label;

    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_cell = w_last_col && (r_row == LAST_ROW);
    assign label_count = r_label_count;
    assign overflow    = r_overflow;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Label decision for the cell being written, from its captured neighbours.
    always_comb begin
        w_need_new = !r_cur_ground && (r_left_lbl == '0) && (r_up_lbl == '0);
        w_eq       = !r_cur_ground && (r_left_lbl != '0) && (r_up_lbl != '0)
                     && (r_left_lbl != r_up_lbl);
        w_min      = (r_left_lbl < r_up_lbl) ? r_left_lbl : r_up_lbl;
        w_max      = (r_left_lbl < r_up_lbl) ? r_up_lbl : r_left_lbl;
        if (r_cur_ground) begin
            w_wr_label = '0;
        end else if (w_need_new) begin
            w_wr_label = r_next_label;
        end else if (r_left_lbl == '0) begin
            w_wr_label = r_up_lbl;
        end else if (r_up_lbl == '0) begin
            w_wr_label = r_left_lbl;
        end else begin
            w_wr_label = w_min;
        end
    end

    // Next-state and output decode; out-of-range neighbour reads fall back to (row, col).
    always_comb begin
        w_state_nxt      = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        mem_we           = 1'b0;
        mem_wr_row       = '0;
        mem_wr_col       = '0;
        mem_wr_label     = '0;
        mem_wr_is_ground = 1'b0;
        mem_rd_row       = '0;
        mem_rd_col       = '0;
        eq_valid         = 1'b0;
        eq_a             = '0;
        eq_b             = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RC;
            end
            S_RC: begin
                busy        = 1'b1;
                mem_rd_row  = r_row;
                mem_rd_col  = r_col;
                w_state_nxt = S_RL;
            end
            S_RL: begin
                busy        = 1'b1;
                mem_rd_row  = r_row;
                mem_rd_col  = (r_col == '0) ? r_col : r_col - 1'b1;
                w_state_nxt = S_RU;
            end
            S_RU: begin
                busy        = 1'b1;
                mem_rd_row  = (r_row == '0) ? r_row : r_row - 1'b1;
                mem_rd_col  = r_col;
                w_state_nxt = S_WU;
            end
            S_WU: begin
                busy        = 1'b1;
                mem_rd_row  = r_row;
                mem_rd_col  = r_col;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                busy             = 1'b1;
                mem_we           = 1'b1;
                mem_wr_row       = r_row;
                mem_wr_col       = r_col;
                mem_wr_label     = w_wr_label;
                mem_wr_is_ground = r_cur_ground;
                eq_valid         = w_eq;
                eq_a             = w_eq ? w_min : '0;
                eq_b             = w_eq ? w_max : '0;
                w_state_nxt      = w_last_cell ? S_DONE : S_RC;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan position, neighbour capture and label allocation bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row         <= '0;
            r_col         <= '0;
            r_next_label  <= LBL_ONE;
            r_label_count <= '0;
            r_overflow    <= 1'b0;
            r_cur_ground  <= 1'b0;
            r_left_lbl    <= '0;
            r_up_lbl      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row         <= '0;
                        r_col         <= '0;
                        r_next_label  <= LBL_ONE;
                        r_label_count <= '0;
                        r_overflow    <= 1'b0;
                    end
                end
                S_RL: r_cur_ground <= mem_rd_is_ground;
                S_RU: r_left_lbl   <= (r_col == '0) ? '0 : mem_rd_label;
                S_WU: r_up_lbl     <= (r_row == '0) ? '0 : mem_rd_label;
                S_WR: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    // The all-ones label is handed out once normally; later requests reuse it and flag overflow.
                    if (w_need_new) begin
                        if (r_next_label != LBL_MAX) begin
                            r_next_label  <= r_next_label + 1'b1;
                            r_label_count <= r_label_count + 1'b1;
                        end else if (r_label_count != LBL_MAX) begin
                            r_label_count <= LBL_MAX;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fcc_label_scan_ctrl.sv
// Bench for fcc_label_scan_ctrl: two 3x3 instances (16-bit and 2-bit labels)
// share clock, reset and start; each has its own grid memory model.
module tb_fcc_label_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic        busy[2], done[2], we[2], wgnd[2], eqv[2], ovf[2], rdg[2];
    logic [7:0]  wrow[2], rrow[2];
    logic [4:0]  wcol[2], rcol[2];
    logic [15:0] wl_a, eqa_a, eqb_a, cnt_a, rdl_a;
    logic [1:0]  wl_b, eqa_b, eqb_b, cnt_b, rdl_b;
    logic [15:0] wl[2], eqa_w[2], eqb_w[2], cnt[2];
    logic [15:0] rdl[2];
    logic [15:0] mem_l[2][9];
    logic        mem_g[2][9];

    assign wl[0] = wl_a;   assign wl[1] = {14'd0, wl_b};
    assign eqa_w[0] = eqa_a; assign eqa_w[1] = {14'd0, eqa_b};
    assign eqb_w[0] = eqb_a; assign eqb_w[1] = {14'd0, eqb_b};
    assign cnt[0] = cnt_a; assign cnt[1] = {14'd0, cnt_b};
    assign rdl_a = rdl[0];
    assign rdl_b = rdl[1][1:0];

    fcc_label_scan_ctrl #(.ROWS(3), .COLS(3), .ROW_W(8), .COL_W(5), .LABEL_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
        .mem_we(we[0]), .mem_wr_row(wrow[0]), .mem_wr_col(wcol[0]), .mem_wr_label(wl_a),
        .mem_wr_is_ground(wgnd[0]), .mem_rd_row(rrow[0]), .mem_rd_col(rcol[0]),
        .mem_rd_label(rdl_a), .mem_rd_is_ground(rdg[0]), .eq_valid(eqv[0]),
        .eq_a(eqa_a), .eq_b(eqb_a), .label_count(cnt_a), .overflow(ovf[0]));

    fcc_label_scan_ctrl #(.ROWS(3), .COLS(3), .ROW_W(8), .COL_W(5), .LABEL_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
        .mem_we(we[1]), .mem_wr_row(wrow[1]), .mem_wr_col(wcol[1]), .mem_wr_label(wl_b),
        .mem_wr_is_ground(wgnd[1]), .mem_rd_row(rrow[1]), .mem_rd_col(rcol[1]),
        .mem_rd_label(rdl_b), .mem_rd_is_ground(rdg[1]), .eq_valid(eqv[1]),
        .eq_a(eqa_b), .eq_b(eqb_b), .label_count(cnt_b), .overflow(ovf[1]));

    function automatic int cell_of(input logic [7:0] r, input logic [4:0] c);
        if (r < 8'd3 && c < 5'd3) return int'(r) * 3 + int'(c);
        return -1;
    endfunction

    // Grid memory: registered read, synchronous write, bench-side preload.
    logic       load_req = 1'b0;
    logic [8:0] load_g = '0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load_req) begin
                for (int i = 0; i < 9; i++) begin
                    mem_g[k][i] <= load_g[i];
                    mem_l[k][i] <= 16'hBEEF;
                end
            end else begin
                if (cell_of(rrow[k], rcol[k]) >= 0) begin
                    rdl[k] <= mem_l[k][cell_of(rrow[k], rcol[k])];
                    rdg[k] <= mem_g[k][cell_of(rrow[k], rcol[k])];
                end
                if (we[k] && cell_of(wrow[k], wcol[k]) >= 0) begin
                    mem_l[k][cell_of(wrow[k], wcol[k])] <= wl[k];
                    mem_g[k][cell_of(wrow[k], wcol[k])] <= wgnd[k];
                end
            end
        end
    end

    // Observation logs.
    logic log_clr = 1'b0;
    int   wr_n[2], wr_order[2][9], wr_lbl[2][9], wr_gnd[2][9];
    int   eq_at[2][9], eqa_l[2][9], eqb_l[2][9];
    int   eq_bad[2], stray[2], oob[2], done_n[2], rise[2], last_cell[2];
    logic ovf_prev[2];

    always @(negedge clk) begin
        int c;
        for (int k = 0; k < 2; k++) begin
            if (log_clr) begin
                wr_n[k] = 0; eq_bad[k] = 0; stray[k] = 0; oob[k] = 0;
                done_n[k] = 0; rise[k] = -1; last_cell[k] = -1;
                for (int i = 0; i < 9; i++) begin
                    wr_order[k][i] = -1; wr_lbl[k][i] = -1; wr_gnd[k][i] = -1;
                    eq_at[k][i] = 0; eqa_l[k][i] = 0; eqb_l[k][i] = 0;
                end
            end else begin
                if (we[k]) begin
                    c = cell_of(wrow[k], wcol[k]);
                    if (wr_n[k] < 9) wr_order[k][wr_n[k]] = c;
                    wr_n[k] = wr_n[k] + 1;
                    if (!busy[k]) stray[k] = stray[k] + 1;
                    if (c >= 0) begin
                        wr_lbl[k][c] = int'(wl[k]);
                        wr_gnd[k][c] = int'(wgnd[k]);
                        last_cell[k] = c;
                        if (eqv[k]) begin
                            eq_at[k][c] = 1;
                            eqa_l[k][c] = int'(eqa_w[k]);
                            eqb_l[k][c] = int'(eqb_w[k]);
                        end
                    end
                end else if (eqv[k]) begin
                    eq_bad[k] = eq_bad[k] + 1;
                end
                if (done[k]) begin
                    done_n[k] = done_n[k] + 1;
                    if (busy[k]) stray[k] = stray[k] + 1;
                end
                if (busy[k] && cell_of(rrow[k], rcol[k]) < 0) oob[k] = oob[k] + 1;
                if (ovf[k] && !ovf_prev[k]) rise[k] = last_cell[k];
            end
            ovf_prev[k] = ovf[k];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d, expected %0d", nm, k, act, exp);
        end
    endtask

    // Expected results for the current scan, per instance.
    int e_lab[2][9], e_eqv[2][9], e_eqa[2][9], e_eqb[2][9];
    int e_cnt[2], e_ovf[2], e_rise[2];

    // Reference: plain raster walk over the grid applying the labelling rules.
    task automatic model(input logic [8:0] g, input int k, input int maxl);
        int allocs = 0;
        int lft, up;
        e_rise[k] = -1;
        for (int i = 0; i < 9; i++) begin
            lft = 0; up = 0;
            if (i % 3 != 0) lft = e_lab[k][i-1];
            if (i >= 3) up = e_lab[k][i-3];
            e_eqv[k][i] = 0; e_eqa[k][i] = 0; e_eqb[k][i] = 0;
            if (g[i]) e_lab[k][i] = 0;
            else if (lft == 0 && up == 0) begin
                allocs++;
                e_lab[k][i] = (allocs < maxl) ? allocs : maxl;
                if (allocs > maxl && e_rise[k] < 0) e_rise[k] = i;
            end
            else if (lft == 0) e_lab[k][i] = up;
            else if (up == 0) e_lab[k][i] = lft;
            else begin
                e_lab[k][i] = (lft < up) ? lft : up;
                if (lft != up) begin
                    e_eqv[k][i] = 1;
                    e_eqa[k][i] = (lft < up) ? lft : up;
                    e_eqb[k][i] = (lft < up) ? up : lft;
                end
            end
        end
        e_cnt[k] = (allocs < maxl) ? allocs : maxl;
        e_ovf[k] = (allocs > maxl) ? 1 : 0;
    endtask

    typedef struct {
        logic [8:0]  gnd;
        logic [35:0] lab16;
        logic [35:0] lab2;
        int cnt16; int cnt2; int rise2;
        int eqcell; int eqa; int eqb;
    } vec_t;
    vec_t tab[6];

    task automatic set_exp(input vec_t v);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
                e_lab[k][i] = (k == 0) ? int'(v.lab16[i*4 +: 4]) : int'(v.lab2[i*4 +: 4]);
                e_eqv[k][i] = (i == v.eqcell) ? 1 : 0;
                e_eqa[k][i] = (i == v.eqcell) ? v.eqa : 0;
                e_eqb[k][i] = (i == v.eqcell) ? v.eqb : 0;
            end
        end
        e_cnt[0] = v.cnt16; e_ovf[0] = 0; e_rise[0] = -1;
        e_cnt[1] = v.cnt2;  e_ovf[1] = (v.rise2 >= 0) ? 1 : 0; e_rise[1] = v.rise2;
    endtask

    task automatic load_and_clear(input logic [8:0] g);
        @(negedge clk);
        load_g = g; load_req = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        #1;
        load_req = 1'b0; log_clr = 1'b0;
    endtask

    task automatic run_scan(input logic [8:0] g, input bit mid_start);
        int lat;
        load_and_clear(g);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        chk("busy_first_rc", 0, int'(busy[0]), 1);
        while (!done[0] && lat < 200) begin
            @(negedge clk);
            lat++;
            start = (mid_start && lat == 20) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("done_latency", 0, lat, 45);
        repeat (8) @(negedge clk);
    endtask

    task automatic verify(input logic [8:0] g);
        for (int k = 0; k < 2; k++) begin
            chk("num_writes", k, wr_n[k], 9);
            for (int n = 0; n < 9; n++) chk("write_order", k, wr_order[k][n], n);
            for (int c = 0; c < 9; c++) begin
                chk("label", k, wr_lbl[k][c], e_lab[k][c]);
                chk("ground_flag", k, wr_gnd[k][c], int'(g[c]));
                chk("eq_valid", k, eq_at[k][c], e_eqv[k][c]);
                if (e_eqv[k][c] != 0) begin
                    chk("eq_a", k, eqa_l[k][c], e_eqa[k][c]);
                    chk("eq_b", k, eqb_l[k][c], e_eqb[k][c]);
                end
            end
            chk("eq_outside_wr", k, eq_bad[k], 0);
            chk("stray_strobe", k, stray[k], 0);
            chk("rd_addr_range", k, oob[k], 0);
            chk("label_count", k, int'(cnt[k]), e_cnt[k]);
            chk("overflow", k, int'(ovf[k]), e_ovf[k]);
            chk("overflow_rise_cell", k, rise[k], e_rise[k]);
            chk("done_pulses", k, done_n[k], 1);
            chk("busy_after", k, int'(busy[k]), 0);
        end
    endtask

    initial begin
        logic [8:0] g;
        int nw;
        tab[0] = '{gnd: 9'h1FF,         lab16: 36'h000000000, lab2: 36'h000000000,
                   cnt16: 0, cnt2: 0, rise2: -1, eqcell: -1, eqa: 0, eqb: 0};
        tab[1] = '{gnd: 9'b111101111,   lab16: 36'h000010000, lab2: 36'h000010000,
                   cnt16: 1, cnt2: 1, rise2: -1, eqcell: -1, eqa: 0, eqb: 0};
        tab[2] = '{gnd: 9'b111000010,   lab16: 36'h000111201, lab2: 36'h000111201,
                   cnt16: 2, cnt2: 2, rise2: -1, eqcell: 5, eqa: 1, eqb: 2};
        tab[3] = '{gnd: 9'b010111010,   lab16: 36'h403000201, lab2: 36'h303000201,
                   cnt16: 4, cnt2: 3, rise2: 8, eqcell: -1, eqa: 0, eqb: 0};
        tab[4] = '{gnd: 9'b000000000,   lab16: 36'h111111111, lab2: 36'h111111111,
                   cnt16: 1, cnt2: 1, rise2: -1, eqcell: -1, eqa: 0, eqb: 0};
        tab[5] = '{gnd: 9'b010101010,   lab16: 36'h504030201, lab2: 36'h303030201,
                   cnt16: 5, cnt2: 3, rise2: 6, eqcell: -1, eqa: 0, eqb: 0};

        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, int'(busy[k]), 0);
            chk("rst_done", k, int'(done[k]), 0);
            chk("rst_we", k, int'(we[k]), 0);
            chk("rst_eq_valid", k, int'(eqv[k]), 0);
            chk("rst_label_count", k, int'(cnt[k]), 0);
            chk("rst_overflow", k, int'(ovf[k]), 0);
            chk("rst_rd_addr", k, int'(rrow[k]) + int'(rcol[k]), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table; entry 2 also pulses start in the middle of the scan.
        for (int t = 0; t < 6; t++) begin
            set_exp(tab[t]);
            run_scan(tab[t].gnd, t == 2);
            verify(tab[t].gnd);
        end

        // Random grids against the reference model.
        for (int r = 0; r < 25; r++) begin
            g = 9'($urandom);
            model(g, 0, 65535);
            model(g, 1, 3);
            run_scan(g, 1'b0);
            verify(g);
        end

        // Asynchronous reset during a write cycle, then a clean rescan.
        load_and_clear(tab[3].gnd);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nw = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (we[0]) nw++;
            if (we[0] && nw >= 4) break;
            @(negedge clk);
        end
        chk("reached_mid_write", 0, int'(we[0]), 1);
        chk("count_before_rst", 0, int'(cnt[0]), 2);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_we", k, int'(we[k]), 0);
            chk("midrst_busy", k, int'(busy[k]), 0);
            chk("midrst_wr_label", k, int'(wl[k]), 0);
            chk("midrst_wr_addr", k, int'(wrow[k]) + int'(wcol[k]), 0);
            chk("midrst_label_count", k, int'(cnt[k]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_exp(tab[2]);
        run_scan(tab[2].gnd, 1'b0);
        verify(tab[2].gnd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
